// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 keypad scan controller:
//            FSM state encoding, row drive patterns, column sample classes
//            and a helper that classifies one synchronized column sample.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_IDLE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } col_class_e;

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0] ROW_HL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    col_class_e cls;
    logic [1:0] col;
  } col_sample_t;

  // Columns are active-low; exactly one zero identifies a single key.
  function automatic col_sample_t classify(input logic [3:0] vs);
    col_sample_t res;
    logic [2:0]  zeros;
    zeros   = 3'd0;
    res.col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!vs[c]) begin
        zeros   = zeros + 3'd1;
        res.col = 2'(c);
      end
    end
    if (zeros == 3'd0) begin
      res.cls = CLS_IDLE;
    end else if (zeros == 3'd1) begin
      res.cls = CLS_SINGLE;
    end else begin
      res.cls = CLS_MULTI;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Parameterised-width two-flop synchronizer; resets to all ones
//            so an idle (active-low) bus reads as inactive after reset.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            d_i   - asynchronous input bus
//            q_o   - synchronized output bus
// Revision : 1.0  initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 matrix keypad sequencer. Drives rows with an active-low
//            one-hot scan, samples synchronized columns once per dwell,
//            debounces press and release, and reports the key code with a
//            one-cycle valid strobe.
// Ports    : clk       - system clock
//            rst       - synchronous active-high reset
//            vl        - column inputs, active-low, asynchronous
//            hl        - row drive, active-low one-hot
//            key_code  - last accepted key (row*4 + col)
//            key_valid - one-cycle pulse on acceptance
//            key_down  - high while a key is held / release is debounced
// Revision : 1.0  initial release
// ============================================================================
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE_N = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] vl,
  output logic [3:0] hl,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_N + 1) + 1;
  localparam logic [CNT_W-1:0] C_SAMPLE  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] C_DEB_N   = DEB_W'(DEBOUNCE_N);
  localparam logic [DEB_W-1:0] C_DEB_ONE = DEB_W'(1);

  logic [3:0]       w_vs;
  col_sample_t      w_samp;
  logic             w_sample;
  logic             w_match;
  logic [DEB_W-1:0] w_deb_inc;

  state_e           state_q,  state_d;
  logic [1:0]       row_q,    row_d;
  logic [1:0]       col_q,    col_d;
  logic [DEB_W-1:0] deb_q,    deb_d;
  logic [CNT_W-1:0] dwell_q;
  logic [3:0]       code_q,   code_d;
  logic             valid_q,  valid_d;
  logic             down_q,   down_d;

  sync2 #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (vl),
    .q_o (w_vs)
  );

  // Free-running dwell counter; never restarted by state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
    end else if (dwell_q == C_SAMPLE) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + CNT_W'(1);
    end
  end

  assign w_sample  = (dwell_q == C_SAMPLE);
  assign w_samp    = classify(w_vs);
  assign w_match   = (w_samp.cls == CLS_SINGLE) && (w_samp.col == col_q);
  assign w_deb_inc = deb_q + C_DEB_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCAN;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      deb_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      deb_q   <= deb_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    deb_d   = deb_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;

    if (w_sample) begin
      unique case (state_q)
        ST_SCAN: begin
          if (w_samp.cls == CLS_SINGLE) begin
            col_d = w_samp.col;
            deb_d = C_DEB_ONE;
            // A single agreeing sample is already enough when N == 1.
            if (C_DEB_ONE == C_DEB_N) begin
              state_d = ST_PRESSED;
              code_d  = {row_q, w_samp.col};
              valid_d = 1'b1;
              down_d  = 1'b1;
            end else begin
              state_d = ST_CONFIRM;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end

        ST_CONFIRM: begin
          if (w_match) begin
            deb_d = w_deb_inc;
            if (w_deb_inc == C_DEB_N) begin
              state_d = ST_PRESSED;
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              down_d  = 1'b1;
            end
          end else begin
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end

        ST_PRESSED: begin
          if (!w_match) begin
            if (w_samp.cls == CLS_IDLE) begin
              deb_d = C_DEB_ONE;
              // With N == 1 this first idle sample completes the release.
              if (C_DEB_ONE == C_DEB_N) begin
                state_d = ST_SCAN;
                down_d  = 1'b0;
                row_d   = row_q + 2'd1;
              end else begin
                state_d = ST_RELEASE;
              end
            end else begin
              deb_d   = '0;
              state_d = ST_RELEASE;
            end
          end
        end

        ST_RELEASE: begin
          if (w_samp.cls == CLS_IDLE) begin
            deb_d = w_deb_inc;
            if (w_deb_inc == C_DEB_N) begin
              state_d = ST_SCAN;
              down_d  = 1'b0;
              row_d   = row_q + 2'd1;
            end
          end else begin
            deb_d = '0;
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  assign hl        = ROW_HL[row_q];
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Self-checking bench for keypad_scan_ctrl. A keypad model turns
//            the pressed-key set and the row drive into column levels; a
//            behavioural reference tracks the expected outputs per cycle.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  vl;
  logic [3:0]  hl;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] keys;   // bit r*4+c set = key (r,c) physically pressed

  int n_vec;
  int n_err;

  keypad_scan_ctrl #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .vl        (vl),
    .hl        (hl),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a column is pulled low when a pressed key sits on a driven row.
  always_comb begin
    vl = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!hl[r] && keys[r*4+c]) vl[c] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 hunting for a key, 1 counting agreeing press samples,
  //       2 key held, 3 counting idle samples for release.
  int         m_mode, m_row, m_col, m_streak, m_tick;
  int         m_code;
  bit         m_valid, m_down;
  logic [3:0] pipe1, pipe2;

  always @(posedge clk) begin : ref_model
    logic [3:0] seen;
    int zeros, col;
    bit agree;
    if (rst) begin
      m_mode = 0; m_row = 0; m_col = 0; m_streak = 0; m_tick = 0;
      m_code = 0; m_valid = 0; m_down = 0;
      pipe1 = 4'hF; pipe2 = 4'hF;
    end else begin
      seen  = pipe2;          // columns as they were two edges ago
      pipe2 = pipe1;
      pipe1 = vl;
      m_valid = 0;
      if (m_tick == SCAN_DIV - 1) begin
        zeros = 0; col = 0;
        for (int c = 0; c < 4; c++) if (!seen[c]) begin zeros++; col = c; end
        agree = (zeros == 1) && (col == m_col);
        case (m_mode)
          0: if (zeros == 1) begin
               m_col = col; m_streak = 1; m_mode = 1;
               if (m_streak >= DEBOUNCE_N) begin
                 m_mode = 2; m_code = m_row * 4 + m_col; m_valid = 1; m_down = 1;
               end
             end else m_row = (m_row + 1) % 4;
          1: if (agree) begin
               m_streak++;
               if (m_streak >= DEBOUNCE_N) begin
                 m_mode = 2; m_code = m_row * 4 + m_col; m_valid = 1; m_down = 1;
               end
             end else begin
               m_mode = 0; m_row = (m_row + 1) % 4;
             end
          2: if (!agree) begin
               m_streak = (zeros == 0) ? 1 : 0; m_mode = 3;
               if (m_streak >= DEBOUNCE_N) begin
                 m_mode = 0; m_down = 0; m_row = (m_row + 1) % 4;
               end
             end
          default: if (zeros == 0) begin
               m_streak++;
               if (m_streak >= DEBOUNCE_N) begin
                 m_mode = 0; m_down = 0; m_row = (m_row + 1) % 4;
               end
             end else m_streak = 0;
        endcase
      end
      m_tick = (m_tick + 1) % SCAN_DIV;
    end
  end

  // ---------------- output comparison ----------------
  bit cnt_en;
  int pulse_cnt;

  always @(negedge clk) begin
    if (cnt_en && key_valid) pulse_cnt++;
    check_eq("hl",        32'(hl),        32'(4'(~(4'b0001 << m_row))));
    check_eq("key_code",  32'(key_code),  32'(m_code));
    check_eq("key_valid", 32'(key_valid), 32'(m_valid));
    check_eq("key_down",  32'(key_down),  32'(m_down));
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] v;
    v = 16'd1 << (r * 4 + c);
    return v;
  endfunction

  initial begin
    int kind, len, a, b;
    n_vec = 0; n_err = 0;
    cnt_en = 0; pulse_cnt = 0;
    keys = 16'd0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check_eq("reset_hl", 32'(hl), 32'(4'b1110));

    // Idle scan: no strobe over several full rotations.
    cnt_en = 1; pulse_cnt = 0;
    run(48);
    check_eq("idle_pulses", 32'(pulse_cnt), 32'd0);

    // Single key (2,1) held, then released.
    pulse_cnt = 0;
    keys = kbit(2, 1);
    run(200);
    check_eq("held_pulses", 32'(pulse_cnt), 32'd1);
    check_eq("held_code",   32'(key_code),  32'd9);
    check_eq("held_hl",     32'(hl),        32'(4'b1011));
    keys = 16'd0;
    run(60);
    check_eq("rel_down",    32'(key_down),  32'd0);
    check_eq("rel_code",    32'(key_code),  32'd9);

    // Short bounce on (0,3): never accepted.
    pulse_cnt = 0;
    keys = kbit(0, 3);
    run(4);
    keys = 16'd0;
    run(60);
    check_eq("bounce_pulses", 32'(pulse_cnt), 32'd0);

    // Ghost press (1,0)+(1,2), then only (1,0) remains.
    pulse_cnt = 0;
    keys = kbit(1, 0) | kbit(1, 2);
    run(100);
    check_eq("multi_pulses", 32'(pulse_cnt), 32'd0);
    keys = kbit(1, 0);
    run(100);
    check_eq("multi_code", 32'(key_code), 32'd4);
    // Release with a one-dwell glitch back to pressed during release.
    keys = 16'd0;
    run(10);
    keys = kbit(1, 0);
    run(4);
    keys = 16'd0;
    run(60);
    check_eq("multi_pulses2", 32'(pulse_cnt), 32'd1);

    // Reset while a key is held; it must be re-accepted once.
    keys = kbit(2, 1);
    run(80);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check_eq("mid_rst_hl",   32'(hl),       32'(4'b1110));
    check_eq("mid_rst_down", 32'(key_down), 32'd0);
    check_eq("mid_rst_code", 32'(key_code), 32'd0);
    pulse_cnt = 0;
    run(100);
    check_eq("reaccept_pulses", 32'(pulse_cnt), 32'd1);
    keys = 16'd0;
    run(60);

    // Randomized key activity checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 80);
      a    = $urandom_range(0, 15);
      b    = $urandom_range(0, 15);
      case (kind)
        0: keys = 16'd0;
        1: keys = 16'd1 << a;
        2: keys = (16'd1 << a) | (16'd1 << b);
        default: begin
          keys = 16'd1 << a;
          run($urandom_range(1, 6));
          keys = 16'd0;
        end
      endcase
      run(len);
    end
    keys = 16'd0;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
